// File: rtl/usb3_tx_replay_fifo.sv
// usb3_tx_replay_fifo
//   Buffers 32-bit link-layer TX words ahead of the scrambler/SKP-insertion
//   stage. One word (or logical idle) is presented per cycle on raw_*. Each
//   word stays in the FIFO until the downstream stage confirms it, which it
//   does STALL_LAT edges after presentation. If it reports a stall instead,
//   the read pointer rewinds and the same word is presented again.
//
// Ports
//   local_clk, reset_n        clock, synchronous active-low reset
//   enable                    link TX enabled (low: idle out, replay frozen)
//   flush                     synchronous clear of FIFO and replay state
//   in_data/in_datak/in_eop   incoming word, K flags, end-of-packet marker
//   in_valid/in_ready         write handshake
//   raw_data/raw_datak        presented word to the scrambler
//   raw_active                1 = real word, 0 = idle fill
//   raw_stall                 word presented STALL_LAT edges ago not consumed
//   fifo_level                words accepted but not yet released
//   err_underrun              1-cycle pulse: idle presented inside a packet
//
// Optional feature (macro USB3_TX_REPLAY_STATS_EN):
//   stat_replays              saturating count of replay events
//   stat_hiwater              highest fifo_level seen
//   Both clear on reset or flush.

module usb3_tx_replay_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int STALL_LAT  = 2
) (
  input  logic                  local_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [31:0]           in_data,
  input  logic [3:0]            in_datak,
  input  logic                  in_eop,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [31:0]           raw_data,
  output logic [3:0]            raw_datak,
  output logic                  raw_active,
  input  logic                  raw_stall,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  err_underrun
`ifdef USB3_TX_REPLAY_STATS_EN
  ,
  output logic [15:0]           stat_replays,
  output logic [DEPTH_LOG2:0]   stat_hiwater
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  k;
    logic        eop;
  } entry_t;

  typedef struct packed {
    logic          active;
    logic [PW-1:0] ptr;
  } hist_t;

  entry_t        mem [DEPTH];
  hist_t         hist_q [STALL_LAT];
  logic [PW-1:0] wr_q, rd_q, cm_q;
  logic          run_q;
  logic          in_pkt_q;
  logic          gap_reported_q;

  hist_t         oldest;
  logic          full, write_en;
  logic          do_replay, do_release, present;
  logic [PW-1:0] sel_ptr;
  entry_t        rd_word;

  // Pointers are one bit wider than the address so full and empty differ.
  assign fifo_level = wr_q - cm_q;
  assign full       = (fifo_level == PW'(DEPTH));
  assign in_ready   = reset_n & run_q & ~full;
  assign write_en   = in_valid & in_ready & ~flush;
  assign oldest     = hist_q[STALL_LAT-1];

  // The oldest history entry is the word whose stall answer arrives now.
  // A replay re-presents that word in place of whatever rd points at.
  always_comb begin
    do_replay  = 1'b0;
    do_release = 1'b0;
    present    = 1'b0;
    sel_ptr    = rd_q;
    if (enable) begin
      do_replay  = raw_stall & oldest.active;
      do_release = ~raw_stall & oldest.active;
      sel_ptr    = do_replay ? oldest.ptr : rd_q;
      present    = do_replay | (rd_q != wr_q);
    end
    rd_word = mem[sel_ptr[DEPTH_LOG2-1:0]];
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge local_clk) begin
    if (write_en)
      mem[wr_q[DEPTH_LOG2-1:0]] <= {in_data, in_datak, in_eop};
  end

  always_ff @(posedge local_clk) begin
    if (!reset_n || flush) begin
      run_q          <= reset_n;
      wr_q           <= '0;
      rd_q           <= '0;
      cm_q           <= '0;
      in_pkt_q       <= 1'b0;
      gap_reported_q <= 1'b0;
      raw_data       <= '0;
      raw_datak      <= '0;
      raw_active     <= 1'b0;
      err_underrun   <= 1'b0;
      for (int i = 0; i < STALL_LAT; i++)
        hist_q[i] <= '0;
    end else begin
      run_q <= 1'b1;
      if (write_en)
        wr_q <= wr_q + PW'(1);
      if (enable) begin
        if (present)
          rd_q <= sel_ptr + PW'(1);
        if (do_release)
          cm_q <= oldest.ptr + PW'(1);
        // A replay discards every younger in-flight word; the replayed word
        // itself becomes the newest history entry.
        for (int i = 1; i < STALL_LAT; i++)
          hist_q[i] <= do_replay ? '0 : hist_q[i-1];
        hist_q[0] <= {present, sel_ptr};
        if (present) begin
          raw_data       <= rd_word.data;
          raw_datak      <= rd_word.k;
          raw_active     <= 1'b1;
          in_pkt_q       <= ~rd_word.eop;
          gap_reported_q <= 1'b0;
          err_underrun   <= 1'b0;
        end else begin
          raw_data       <= '0;
          raw_datak      <= '0;
          raw_active     <= 1'b0;
          // Report only the first idle of a gap inside a packet.
          err_underrun   <= in_pkt_q & ~gap_reported_q;
          if (in_pkt_q)
            gap_reported_q <= 1'b1;
        end
      end else begin
        raw_data     <= '0;
        raw_datak    <= '0;
        raw_active   <= 1'b0;
        err_underrun <= 1'b0;
      end
    end
  end

`ifdef USB3_TX_REPLAY_STATS_EN
  // Replay counter saturates; high-water mark tracks the registered level.
  always_ff @(posedge local_clk) begin
    if (!reset_n || flush) begin
      stat_replays <= '0;
      stat_hiwater <= '0;
    end else begin
      if (do_replay && stat_replays != 16'hFFFF)
        stat_replays <= stat_replays + 16'd1;
      if (fifo_level > stat_hiwater)
        stat_hiwater <= fifo_level;
    end
  end
`endif

endmodule
